// File: rtl/mem_protocol_checker_if.sv
// mem_protocol_checker_if: observed valid/ready memory bus plus checker result signals.
// The master modport is the side driving the memory bus (requester and memory model).
// The slave modport is the passive checker, which only reads the bus and drives results.
interface mem_protocol_checker_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                  valid_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [WIDTH-1:0]      wdata_i;
    logic                  wr_rd_i;
    logic                  ready_o;
    logic [WIDTH-1:0]      rdata_o;
    logic [3:0]            err_o;
    logic                  err_pulse_o;
    logic [CNT_WIDTH-1:0]  err_cnt_o;
    logic [CNT_WIDTH-1:0]  txn_cnt_o;

    modport master (
        output valid_i, addr_i, wdata_i, wr_rd_i, ready_o, rdata_o,
        input  err_o, err_pulse_o, err_cnt_o, txn_cnt_o
    );

    modport slave (
        input  valid_i, addr_i, wdata_i, wr_rd_i, ready_o, rdata_o,
        output err_o, err_pulse_o, err_cnt_o, txn_cnt_o
    );
endinterface

// File: rtl/mem_protocol_checker.sv
// mem_protocol_checker: passive checker and scoreboard for a single-port valid/ready memory.
// It detects handshake timeout, request instability, read-data mismatch against a shadow
// copy and (optionally) unknown values. Results are sticky flags, a one-cycle pulse and
// saturating counters.
// Optional feature: define MEM_CHK_XCHECK_EN to enable the X-propagation check (err_o[3]);
// without it err_o[3] stays 0.
module mem_protocol_checker #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned MAX_WAIT   = 1,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic                   clk_i,
    input logic                   reset_i,
    mem_protocol_checker_if.slave bus
);
    // Wide enough to count past MAX_WAIT so the timeout compare matches only once per request.
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 2);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [WIDTH-1:0]      cap_wdata;
    logic                  cap_wr;
    logic [WAIT_W-1:0]     wait_cnt;

    logic [WIDTH-1:0]      shadow [DEPTH];
    logic [DEPTH-1:0]      shadow_vld;
    logic                  chk_pend;
    logic [WIDTH-1:0]      chk_exp;

    logic                  hs;
    logic                  addr_ok;
    logic                  rd_hit;
    logic                  x_rd;
    logic [3:0]            det;

    // Handshake decode and per-cycle error detection.
    always_comb begin
        hs      = bus.valid_i && bus.ready_o;
        addr_ok = (32'(bus.addr_i) < DEPTH);
        rd_hit  = hs && !bus.wr_rd_i && addr_ok && shadow_vld[bus.addr_i];
        det     = '0;
        x_rd    = 1'b0;
`ifdef MEM_CHK_XCHECK_EN
        x_rd = chk_pend && $isunknown(bus.rdata_o);
`endif
        if (state == ST_WAIT) begin
            if (!bus.valid_i) begin
                det[1] = 1'b1;
            end else begin
                if ((bus.addr_i != cap_addr) || (bus.wr_rd_i != cap_wr) ||
                    (cap_wr && (bus.wdata_i != cap_wdata))) begin
                    det[1] = 1'b1;
                end
                if (!bus.ready_o && (wait_cnt == WAIT_W'(MAX_WAIT))) begin
                    det[0] = 1'b1;
                end
            end
        end
        if (chk_pend && !x_rd && (bus.rdata_o != chk_exp)) begin
            det[2] = 1'b1;
        end
`ifdef MEM_CHK_XCHECK_EN
        if (hs && ($isunknown(bus.addr_i) || $isunknown(bus.wr_rd_i) ||
                   (bus.wr_rd_i && $isunknown(bus.wdata_i)))) begin
            det[3] = 1'b1;
        end
        if (x_rd) begin
            det[3] = 1'b1;
        end
`endif
    end

    // Request FSM: captures a stalled request and tracks how long it has waited.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wr    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid_i && !bus.ready_o) begin
                        cap_addr  <= bus.addr_i;
                        cap_wdata <= bus.wdata_i;
                        cap_wr    <= bus.wr_rd_i;
                        wait_cnt  <= WAIT_W'(1);
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus.valid_i || bus.ready_o) begin
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Shadow data array; contents are only trusted where shadow_vld is set, so no reset.
    always_ff @(posedge clk_i) begin
        if (hs && bus.wr_rd_i && addr_ok) begin
            shadow[bus.addr_i] <= bus.wdata_i;
        end
    end

    // Shadow-valid bits and the read-check snapshot taken at each checked read handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_vld <= '0;
            chk_pend   <= 1'b0;
            chk_exp    <= '0;
        end else begin
            chk_pend <= rd_hit;
            if (rd_hit) begin
                chk_exp <= shadow[bus.addr_i];
            end
            if (hs && bus.wr_rd_i && addr_ok) begin
                shadow_vld[bus.addr_i] <= 1'b1;
            end
        end
    end

    // Sticky flags, detection pulse and saturating counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bus.err_o       <= '0;
            bus.err_pulse_o <= 1'b0;
            bus.err_cnt_o   <= '0;
            bus.txn_cnt_o   <= '0;
        end else begin
            bus.err_o       <= bus.err_o | det;
            bus.err_pulse_o <= |det;
            if ((|det) && (bus.err_cnt_o != '1)) begin
                bus.err_cnt_o <= bus.err_cnt_o + 1'b1;
            end
            if (hs && (bus.txn_cnt_o != '1)) begin
                bus.txn_cnt_o <= bus.txn_cnt_o + 1'b1;
            end
        end
    end
endmodule

// File: doc/mem_protocol_checker.md
# mem_protocol_checker

Synthesizable, parametrised protocol checker and scoreboard for the single-port valid/ready memory interface. It sits passively beside any memory instance and observes the same request and response signals. It detects four fault classes: handshake timeout, request instability, read-data mismatch against a shadow copy, and unknown values. Faults are reported as sticky flags, a one-cycle pulse and saturating counters, so the same checks run in simulation, emulation and FPGA debug builds.

## Interface
- WIDTH, 16, data width in bits
- DEPTH, 64, memory depth in words
- ADDR_WIDTH, $clog2(DEPTH), address width
- MAX_WAIT, 1, cycles allowed from the first cycle of valid_i to ready_o (≥1)
- CNT_WIDTH, 8, width of the error and transaction counters

Ports (clock and reset first):
- clk_i  in  1  sole clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- valid_i  in  1  observed request valid
- addr_i  in  ADDR_WIDTH  observed request address
- wdata_i  in  WIDTH  observed write data
- wr_rd_i  in  1  observed direction: 1 = write, 0 = read
- ready_o  in  1  observed memory ready; handshake = valid_i && ready_o in the same cycle
- rdata_o  in  WIDTH  observed read data, valid the cycle after a read handshake
- err_o  out  4  sticky flags: [0] TIMEOUT, [1] UNSTABLE, [2] RDATA, [3] XPROP
- err_pulse_o  out  1  high for one cycle for each cycle in which at least one new error is detected
- err_cnt_o  out  CNT_WIDTH  saturating count of error-detection cycles
- txn_cnt_o  out  CNT_WIDTH  saturating count of completed handshakes

## Operation
- Reset: every output is 0, all shadow-valid bits are cleared, wait_cnt = 0, the pending read check is dropped, and the FSM is in IDLE.
- FSM states:
  - IDLE: no request pending.
    - valid_i && ready_o → handshake; stay in IDLE.
    - valid_i && !ready_o → capture addr_i, wr_rd_i and wdata_i; set wait_cnt = 1; go to WAIT.
  - WAIT:
    - Each cycle, compare the live addr_i and wr_rd_i against the captured values. Compare wdata_i only for writes. Any difference raises UNSTABLE.
    - valid_i low before handshake → UNSTABLE (request withdrawn); go to IDLE.
    - ready_o high → handshake; go to IDLE.
    - Otherwise wait_cnt increments and saturates. When wait_cnt == MAX_WAIT while still not ready, raise TIMEOUT once per request; stay in WAIT.
- Write handshake: shadow[addr_i] ← wdata_i; shadow_valid[addr_i] ← 1.
- Read handshake:
  - If shadow_valid[addr_i] is set, snapshot expected = shadow[addr_i] and set chk_pend.
  - Next cycle, if rdata_o != expected, raise RDATA. Clear chk_pend.
  - Reads of never-written addresses are not checked.
- Back-to-back reads: a check and a new snapshot in the same cycle are both serviced; chk_pend remains set.
- Write to the same address in the cycle after a read: the compare uses the snapshot, not the updated shadow.
- Counters: txn_cnt_o increments on every handshake. err_cnt_o increments once per detection cycle, not once per flag. Both hold at 2^CNT_WIDTH−1.
- Flags in err_o clear only on reset_i.

## Timing
- Detection is combinational on cycle t. err_o, err_pulse_o and the counters update at the edge ending t and are visible in cycle t+1.
- With MAX_WAIT = 1: valid_i high at t0 and ready_o high at t0+1 passes. ready_o still low at t0+1 sets err_o[0] in cycle t0+2.
- RDATA latency: read handshake at t, compare at t+1, flag visible at t+2.
- Reset asserted mid-WAIT or with a check pending: no flag is raised for that transaction, and outputs are 0 from the next cycle.
- Several errors in one cycle: all corresponding flags set, one err_pulse_o, err_cnt_o +1.

## Configuration
- MEM_CHK_XCHECK_EN defined:
  - On every handshake, `$isunknown` is evaluated on addr_i and wr_rd_i, and on wdata_i for writes.
  - On the compare cycle, `$isunknown` is evaluated on rdata_o.
  - Any unknown raises XPROP (err_o[3]). An unknown rdata_o also suppresses the RDATA compare.
- MEM_CHK_XCHECK_EN undefined: the X logic is removed for synthesis and err_o[3] is tied to 0.

## Test plan
- Write 0xA5A5 to addr 3, ready_o one cycle later, then read addr 3 with rdata_o = 0xA5A5 → err_o = 0, txn_cnt_o = 2.
- Same sequence with rdata_o = 0x1234 → err_o = 4'b0100 two cycles after the read handshake, err_pulse_o high for 1 cycle, err_cnt_o = 1.
- MAX_WAIT = 1, valid_i held 3 cycles with ready_o low → err_o[0] set exactly once, err_cnt_o = 1.
- While waiting, addr_i changes from 5 to 6 → err_o[1] set. Also drop valid_i before ready_o in a separate request → err_o[1] set.
- Read of an unwritten addr 10 with rdata_o = 0xFFFF → no error. Then assert reset_i for 1 cycle mid-WAIT → all outputs 0 and shadow-valid cleared.
- With MEM_CHK_XCHECK_EN, write handshake with wdata_i = 'x → err_o[3] set. Without the macro, the same stimulus leaves err_o[3] = 0.
